// File: rtl/move_input_ctrl.sv
// Button front end for the tic-tac-toe game model: synchronise, debounce, cursor, and a
// writeEn pulse/gap sequencer. Define OCCUPIED_FILTER_EN to refuse places on occupied cells.
module move_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_LEN       = 4,
   parameter int GAP_LEN         = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_place,
   input  logic [8:0] X,
   input  logic [8:0] O,
   input  logic       game_over,
   output logic [8:0] C,
   output logic       writeEn,
   output logic [1:0] cursor_row,
   output logic [1:0] cursor_col,
   output logic       reject
);

   localparam int             CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]     PULSE_LAST = 4'(PULSE_LEN - 1);
   localparam logic [3:0]     GAP_LAST   = 4'(GAP_LEN - 1);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   // Button index: 0 up, 1 down, 2 left, 3 right, 4 place.
   logic [4:0]    raw, sync_a, sync_b, stable, stable_d, press;
   logic [CW-1:0] db_cnt [5];

   assign raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

   // NOTE: every register in this file is assigned with <= so all flops sample the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a   <= '0;
         sync_b   <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync_a   <= raw;
         sync_b   <= sync_a;
         stable_d <= stable;
         for (int i = 0; i < 5; i++) begin
            if (sync_b[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_MAX) begin
               stable[i] <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = stable & ~stable_d;

   function automatic logic [8:0] cell_onehot(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] idx;
      idx = {2'b00, r} * 4'd3 + {2'b00, c};
      return 9'b1 << idx;
   endfunction

`ifdef OCCUPIED_FILTER_EN
   logic occupied;
   assign occupied = |((X | O) & C);
`else
   logic unused_occ;
   assign unused_occ = ^{X, O};
`endif

   state_t     state, state_n;
   logic [3:0] timer, timer_n;
   logic [1:0] row_n, col_n;
   logic       reject_n;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      row_n    = cursor_row;
      col_n    = cursor_col;
      reject_n = 1'b0;
      case (state)
         IDLE: begin
            // Priority chain: place discards any simultaneous move event.
            if (press[4]) begin
               if (!game_over) begin
`ifdef OCCUPIED_FILTER_EN
                  if (occupied) begin
                     reject_n = 1'b1;
                  end else begin
                     state_n = PULSE;
                     timer_n = '0;
                  end
`else
                  state_n = PULSE;
                  timer_n = '0;
`endif
               end
            end else if (press[0]) begin
               row_n = (cursor_row == 2'd0) ? 2'd2 : cursor_row - 2'd1;
            end else if (press[1]) begin
               row_n = (cursor_row == 2'd2) ? 2'd0 : cursor_row + 2'd1;
            end else if (press[2]) begin
               col_n = (cursor_col == 2'd0) ? 2'd2 : cursor_col - 2'd1;
            end else if (press[3]) begin
               col_n = (cursor_col == 2'd2) ? 2'd0 : cursor_col + 2'd1;
            end
         end
         PULSE: begin
            if (timer == PULSE_LAST) begin
               state_n = GAP;
               timer_n = '0;
            end else begin
               timer_n = timer + 4'd1;
            end
         end
         GAP: begin
            if (timer == GAP_LAST) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
         end
      endcase
   end

   // NOTE: only control state is reset here; there is no storage array that would need it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         cursor_row <= 2'd1;
         cursor_col <= 2'd1;
         C          <= 9'b000010000;
         reject     <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         cursor_row <= row_n;
         cursor_col <= col_n;
         C          <= cell_onehot(row_n, col_n);
         reject     <= reject_n;
      end
   end

   assign writeEn = (state == PULSE);

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl: expected moves, pulses and rejects are queued at
// stimulus time and matched by a negedge monitor. Honours OCCUPIED_FILTER_EN like the RTL.
module tb_move_input_ctrl;

   localparam int DEB   = 4;
   localparam int PLEN  = 4;
   localparam int GLEN  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] btn;
   logic [8:0] x_occ, o_occ;
   logic       game_over;
   logic [8:0] C;
   logic       writeEn, reject;
   logic [1:0] cursor_row, cursor_col;

   move_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .PULSE_LEN(PLEN), .GAP_LEN(GLEN)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_place(btn[4]),
      .X(x_occ), .O(o_occ), .game_over(game_over),
      .C(C), .writeEn(writeEn), .cursor_row(cursor_row), .cursor_col(cursor_col), .reject(reject)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef enum int {K_MOVE, K_PULSE, K_REJECT} kind_e;
   typedef struct {
      kind_e      kind;
      logic [1:0] row;
      logic [1:0] col;
      logic [8:0] c;
   } exp_t;

   exp_t exp_q[$];
   int   m_row, m_col;
   bit   mon_en;

   function automatic logic [8:0] onehot(input int r, input int c);
      logic [8:0] v;
      v = '0;
      v[r*3+c] = 1'b1;
      return v;
   endfunction

   function automatic exp_t mk(input kind_e k);
      exp_t e;
      e.kind = k;
      e.row  = 2'(m_row);
      e.col  = 2'(m_col);
      e.c    = onehot(m_row, m_col);
      return e;
   endfunction

   // Monitor: samples on the falling edge and matches DUT activity to the queue.
   initial begin
      logic [1:0] p_row, p_col;
      logic       p_we, p_rej;
      int         hi_len, lo_len, rej_len;
      bit         had_pulse;
      logic [8:0] pulse_c;
      exp_t       e;
      p_row = '0; p_col = '0; p_we = 1'b0; p_rej = 1'b0;
      hi_len = 0; lo_len = 0; rej_len = 0; had_pulse = 0; pulse_c = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            p_row = cursor_row; p_col = cursor_col; p_we = writeEn; p_rej = reject;
            hi_len = 0; lo_len = 0; rej_len = 0; had_pulse = 0;
         end else begin
            if (cursor_row !== p_row || cursor_col !== p_col) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_move", {cursor_row, cursor_col}, {p_row, p_col});
               end else begin
                  e = exp_q.pop_front();
                  check("move_kind", e.kind, K_MOVE);
                  check("move_row", cursor_row, e.row);
                  check("move_col", cursor_col, e.col);
                  check("move_c", C, e.c);
               end
            end
            if (writeEn && !p_we) begin
               if (had_pulse) check("gap_len_ok", lo_len >= GLEN, 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", writeEn, 1'b0);
                  pulse_c = C;
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_kind", e.kind, K_PULSE);
                  pulse_c = e.c;
               end
               hi_len = 0;
            end
            if (writeEn) begin
               hi_len++;
               lo_len = 0;
               check("pulse_c_stable", C, pulse_c);
            end else begin
               if (p_we) begin
                  check("pulse_len", hi_len, PLEN);
                  had_pulse = 1;
               end
               lo_len++;
            end
            if (reject && !p_rej) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_reject", reject, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("reject_kind", e.kind, K_REJECT);
               end
               rej_len = 0;
            end
            if (reject) rej_len++;
            if (!reject && p_rej) check("reject_len", rej_len, 1);
            p_row = cursor_row; p_col = cursor_col; p_we = writeEn; p_rej = reject;
         end
      end
   end

   task automatic press(input int idx, input int hold);
      btn[idx] = 1'b1;
      repeat (hold) @(negedge clk);
      btn[idx] = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic do_move(input int idx);
      case (idx)
         0: m_row = (m_row == 0) ? 2 : m_row - 1;
         1: m_row = (m_row == 2) ? 0 : m_row + 1;
         2: m_col = (m_col == 0) ? 2 : m_col - 1;
         default: m_col = (m_col == 2) ? 0 : m_col + 1;
      endcase
      exp_q.push_back(mk(K_MOVE));
      press(idx, 20);
   endtask

   initial begin
      int waited;
      reset = 1'b1; btn = '0; x_occ = '0; o_occ = '0; game_over = 1'b0;
      mon_en = 0; m_row = 1; m_col = 1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_c", C, 9'h010);
      check("rst_row", cursor_row, 1);
      check("rst_col", cursor_col, 1);
      check("rst_we", writeEn, 0);
      check("rst_reject", reject, 0);
      mon_en = 1;

      // 3-cycle glitch must not survive a 4-cycle debounce.
      press(0, 3);
      check("glitch_row", cursor_row, 1);
      do_move(0);
      check("up_c", C, 9'h002);
      do_move(0);
      check("up_wrap_c", C, 9'h080);

      // Place, with right pressed so its event lands inside the pulse.
      exp_q.push_back(mk(K_PULSE));
      btn[4] = 1'b1;
      repeat (2) @(negedge clk);
      btn[3] = 1'b1;
      repeat (20) @(negedge clk);
      btn = '0;
      repeat (20) @(negedge clk);
      check("right_in_pulse_col", cursor_col, 2'(m_col));
      check("sb_drained_place", exp_q.size(), 0);

      // Place and left debounce together: place wins, left discarded.
      exp_q.push_back(mk(K_PULSE));
      btn = 5'b10100;
      repeat (20) @(negedge clk);
      btn = '0;
      repeat (20) @(negedge clk);
      check("prio_col", cursor_col, 2'(m_col));
      check("sb_drained_prio", exp_q.size(), 0);

      // Place onto an occupied cell.
      x_occ = 9'h080;
`ifdef OCCUPIED_FILTER_EN
      exp_q.push_back(mk(K_REJECT));
`else
      exp_q.push_back(mk(K_PULSE));
`endif
      press(4, 20);
      x_occ = '0;
      check("sb_drained_occ", exp_q.size(), 0);

      // Reset in the second pulse cycle.
      exp_q.push_back(mk(K_PULSE));
      btn[4] = 1'b1;
      waited = 0;
      while (!writeEn && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("we_seen_before_reset", writeEn, 1);
      btn[4] = 1'b0;
      @(negedge clk);
      mon_en = 0;
      reset  = 1'b1;
      @(negedge clk);
      check("mid_rst_we", writeEn, 0);
      check("mid_rst_row", cursor_row, 1);
      check("mid_rst_col", cursor_col, 1);
      check("mid_rst_c", C, 9'h010);
      @(negedge clk);
      reset = 1'b0;
      m_row = 1; m_col = 1;
      repeat (5) @(negedge clk);
      mon_en = 1;
      check("sb_drained_rst", exp_q.size(), 0);

      // Remaining directions and wraps.
      do_move(1);
      do_move(3);
      do_move(3);
      do_move(2);
      do_move(0);
      do_move(1);
      do_move(1);
      check("down_wrap_row", cursor_row, 0);

      // game_over drops places silently.
      game_over = 1'b1;
      btn[4] = 1'b1;
      repeat (12) @(negedge clk);
      check("go_we", writeEn, 0);
      check("go_reject", reject, 0);
      btn[4] = 1'b0;
      repeat (20) @(negedge clk);
      game_over = 1'b0;

      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
